// File: rtl/shared_mem_port_if.sv
// Core-side command/response channel plus the arbitrated shared-memory request bus
// for one processor port. slave = the requester block, master = core + memory side.
interface shared_mem_port_if #(
  parameter int BUS_SIZE  = 160,
  parameter int ADDR_SIZE = 24,
  parameter int WAIT_W    = 8
);
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic                 i_cmd_we;
  logic [ADDR_SIZE-1:0] i_cmd_addr;
  logic [BUS_SIZE-1:0]  i_cmd_wdata;
  logic [2:0]           i_cmd_size;
  logic                 o_rsp_valid;
  logic                 i_rsp_ready;
  logic [BUS_SIZE-1:0]  o_rsp_rdata;
  logic [WAIT_W-1:0]    o_wait_cycles;
  logic                 o_req_rd;
  logic                 o_req_wr;
  logic                 i_grant_rd;
  logic                 i_grant_wr;
  logic [ADDR_SIZE-1:0] o_mem_addr;
  logic [BUS_SIZE-1:0]  o_mem_wdata;
  logic [2:0]           o_mem_size;
  logic [BUS_SIZE-1:0]  i_mem_rd_data;

  modport slave (
    input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_cmd_size,
    input  i_rsp_ready, i_grant_rd, i_grant_wr, i_mem_rd_data,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_wait_cycles,
    output o_req_rd, o_req_wr, o_mem_addr, o_mem_wdata, o_mem_size
  );

  modport master (
    output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_wdata, i_cmd_size,
    output i_rsp_ready, i_grant_rd, i_grant_wr, i_mem_rd_data,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_wait_cycles,
    input  o_req_rd, o_req_wr, o_mem_addr, o_mem_wdata, o_mem_size
  );
endinterface

// File: rtl/shared_mem_port.sv
// Single-outstanding requester toward the arbitrated shared scratchpad: accepts one core
// command, holds the request until granted, returns read data and the grant wait time.
module shared_mem_port #(
  parameter int BUS_SIZE   = 160,
  parameter int ADDR_SIZE  = 24,
  parameter int RD_LATENCY = 1,
  parameter int WAIT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  shared_mem_port_if.slave bus
);
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, REQ_RD, REQ_WR, RD_WAIT, RSP} state_t;

  state_t               state_reg;
  logic                 cmd_ready_reg;
  logic                 req_rd_reg;
  logic                 req_wr_reg;
  logic                 rsp_valid_reg;
  logic [ADDR_SIZE-1:0] addr_reg;
  logic [BUS_SIZE-1:0]  wdata_reg;
  logic [BUS_SIZE-1:0]  rdata_reg;
  logic [2:0]           size_reg;
  logic [WAIT_W-1:0]    wait_cnt_reg;
  logic [WAIT_W-1:0]    wait_out_reg;
  logic [LAT_W-1:0]     lat_cnt_reg;
  logic                 wait_sat;

  assign wait_sat = &wait_cnt_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b0;
      req_rd_reg    <= 1'b0;
      req_wr_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      size_reg      <= '0;
      wait_cnt_reg  <= '0;
      wait_out_reg  <= '0;
      lat_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // ready comes up one edge after reset release, then stays up while idle
          if (bus.i_cmd_valid && cmd_ready_reg) begin
            cmd_ready_reg <= 1'b0;
            addr_reg      <= bus.i_cmd_addr;
            wdata_reg     <= bus.i_cmd_wdata;
            size_reg      <= bus.i_cmd_size;
            wait_cnt_reg  <= '0;
            if (bus.i_cmd_we) begin
              req_wr_reg <= 1'b1;
              state_reg  <= REQ_WR;
            end else begin
              req_rd_reg <= 1'b1;
              state_reg  <= REQ_RD;
            end
          end else begin
            cmd_ready_reg <= 1'b1;
          end
        end
        REQ_WR: begin
          if (bus.i_grant_wr) begin
            req_wr_reg    <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rdata_reg     <= '0;
            wait_out_reg  <= wait_cnt_reg;
            state_reg     <= RSP;
          end else if (!wait_sat) begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        REQ_RD: begin
          if (bus.i_grant_rd) begin
            req_rd_reg   <= 1'b0;
            lat_cnt_reg  <= LAT_W'(RD_LATENCY - 1);
            wait_out_reg <= wait_cnt_reg;
            state_reg    <= RD_WAIT;
          end else if (!wait_sat) begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        RD_WAIT: begin
          // the shared read bus only carries our data on this one edge
          if (lat_cnt_reg == '0) begin
            rdata_reg     <= bus.i_mem_rd_data;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RSP;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
          end
        end
        RSP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready   = cmd_ready_reg;
  assign bus.o_rsp_valid   = rsp_valid_reg;
  assign bus.o_rsp_rdata   = rdata_reg;
  assign bus.o_wait_cycles = wait_out_reg;
  assign bus.o_req_rd      = req_rd_reg;
  assign bus.o_req_wr      = req_wr_reg;
  assign bus.o_mem_addr    = addr_reg;
  assign bus.o_mem_wdata   = wdata_reg;
  assign bus.o_mem_size    = size_reg;
endmodule
